lz77_greedy: RTL and testbench

Byte-serial greedy LZ77 tokenizer feeding the fixed-Huffman zlib bitstream stage. It accepts one raw byte per cycle under a valid/ready handshake and emits literal/match tokens on the token bus consumed by that stage. The token bus signals are `val_o`, `flg_lit_o`, `lit_dat_o`, `len_dat_o`, `dis_dat_o` and `lst_o`. It shares `start_i` with the bitstream stage and honours that stage's no-backpressure, header-first timing.

---
 rtl/lz77_greedy.sv | 220 ++++++++++++++++++++++
 tb/tb_lz77_greedy.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lz77_greedy.sv
// -----------------------------------------------------------------------------
// lz77_greedy
// Byte-serial greedy LZ77 tokenizer. Raw bytes enter under valid/ready. Tokens
// leave on a token bus with no backpressure: one literal or one
// (length, distance) match per val_o cycle, in stream order.
//
// Architecture: a 128-entry circular byte buffer holds the sliding history
// (up to WINDOW_SIZE bytes behind the current position p) plus a lookahead
// (bytes at p and beyond). Input is accepted until the lookahead holds
// NICE_MATCH bytes. Then one token is emitted per cycle. Each token comes from
// a full parallel comparison of the lookahead against every distance. After
// the last byte arrives, the lookahead is drained at one token per cycle.
// Matches near the end of the stream are therefore capped by the bytes still
// pending.
//
// Ports:
//   clk        clock, rising edge
//   rstn       synchronous active-low reset
//   start_i    stream start pulse (honoured in IDLE only)
//   val_i      input byte valid
//   dat_i      input byte
//   lst_i      marks the accepted byte as the last of the stream
//   rdy_o      input ready
//   val_o      token valid (one cycle per token)
//   flg_lit_o  1 = literal, 0 = match
//   lit_dat_o  literal byte (0 for matches)
//   len_dat_o  match length (0 for literals)
//   dis_dat_o  match distance (0 for literals)
//   lst_o      final token of the stream
//   done_o     pulse one cycle after the final token
// -----------------------------------------------------------------------------
module lz77_greedy #(
    parameter int WINDOW_SIZE = 32,
    parameter int NICE_MATCH  = 32
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start_i,
    input  logic       val_i,
    input  logic [7:0] dat_i,
    input  logic       lst_i,
    output logic       rdy_o,
    output logic       val_o,
    output logic       flg_lit_o,
    output logic [7:0] lit_dat_o,
    output logic [6:0] len_dat_o,
    output logic [6:0] dis_dat_o,
    output logic       lst_o,
    output logic       done_o
);

    // Window plus lookahead never exceeds 128 bytes, so a 7-bit pointer that
    // wraps naturally addresses the circular buffer.
    localparam int DEPTH = 128;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_FLUSH,
        S_FIN
    } state_t;

    state_t      r_state;
    logic [1:0]  r_hold_cnt;
    logic [6:0]  r_pp;      // buffer slot of current position p
    logic [6:0]  r_avail;   // lookahead bytes pending at p
    logic [6:0]  r_hist;    // valid history bytes, min(p, WINDOW_SIZE)

    // Kept in flops rather than block RAM: every lookahead byte is compared
    // against every distance in the same cycle.
    logic [7:0]  r_buf [DEPTH];

    logic [WINDOW_SIZE-1:0][NICE_MATCH-1:0] w_eq;
    logic [6:0]  w_len_d;
    logic        w_alive;
    logic [6:0]  w_best_len;
    logic [6:0]  w_best_dis;
    logic        w_is_match;
    logic [6:0]  w_adv;
    logic        w_accept;
    logic        w_emit;
    logic [6:0]  w_avail_next;
    logic [7:0]  w_hist_sum;

    // Comparator grid: w_eq[gi][gk] is set when in[p+gk] == in[p+gk-(gi+1)].
    generate
        for (genvar gi = 0; gi < WINDOW_SIZE; gi++) begin : g_dist
            for (genvar gk = 0; gk < NICE_MATCH; gk++) begin : g_pos
                assign w_eq[gi][gk] =
                    (r_buf[r_pp + 7'(gk)] == r_buf[r_pp + 7'(gk) - 7'(gi + 1)]);
            end
        end
    endgenerate

    // Compute the run length for each distance, capped at the pending
    // lookahead. Keep the longest run. The strict '>' keeps the smallest
    // distance on ties.
    always_comb begin
        w_best_len = '0;
        w_best_dis = '0;
        w_len_d    = '0;
        w_alive    = 1'b0;
        for (int d = 0; d < WINDOW_SIZE; d++) begin
            w_len_d = '0;
            w_alive = 1'b1;
            for (int k = 0; k < NICE_MATCH; k++) begin
                if (w_alive && w_eq[d][k] && (7'(k) < r_avail)) begin
                    w_len_d = w_len_d + 7'd1;
                end else begin
                    w_alive = 1'b0;
                end
            end
            if (7'(d + 1) > r_hist) begin
                w_len_d = '0;
            end
            if (w_len_d > w_best_len) begin
                w_best_len = w_len_d;
                w_best_dis = 7'(d + 1);
            end
        end
    end

    assign w_is_match   = (w_best_len >= 7'd3);
    assign w_adv        = w_is_match ? w_best_len : 7'd1;
    assign w_accept     = val_i && rdy_o;
    // Emit once the lookahead is full, or while draining after the last byte.
    assign w_emit       = ((r_state == S_RUN) && (r_avail >= 7'(NICE_MATCH))) ||
                          ((r_state == S_FLUSH) && (r_avail != 7'd0));
    assign w_avail_next = r_avail + {6'd0, w_accept} - (w_emit ? w_adv : 7'd0);
    assign w_hist_sum   = {1'b0, r_hist} + {1'b0, w_adv};

    // New bytes land just past the pending lookahead.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_pp + r_avail] <= dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            r_pp       <= '0;
            r_avail    <= '0;
            r_hist     <= '0;
            rdy_o      <= 1'b0;
            val_o      <= 1'b0;
            flg_lit_o  <= 1'b0;
            lit_dat_o  <= '0;
            len_dat_o  <= '0;
            dis_dat_o  <= '0;
            lst_o      <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            // Token fields are zero in every cycle without a token.
            rdy_o     <= 1'b0;
            val_o     <= 1'b0;
            flg_lit_o <= 1'b0;
            lit_dat_o <= '0;
            len_dat_o <= '0;
            dis_dat_o <= '0;
            lst_o     <= 1'b0;
            done_o    <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        // Start a fresh history, so no match reaches into an
                        // earlier stream.
                        r_state    <= S_HOLD;
                        r_hold_cnt <= '0;
                        r_pp       <= '0;
                        r_avail    <= '0;
                        r_hist     <= '0;
                    end
                end
                S_HOLD: begin
                    // Three quiet cycles while the downstream stage sends its
                    // header.
                    if (r_hold_cnt == 2'd2) begin
                        r_state <= S_RUN;
                        rdy_o   <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 2'd1;
                    end
                end
                S_RUN, S_FLUSH: begin
                    if (w_emit) begin
                        val_o     <= 1'b1;
                        flg_lit_o <= !w_is_match;
                        lit_dat_o <= w_is_match ? 8'd0 : r_buf[r_pp];
                        len_dat_o <= w_is_match ? w_best_len : 7'd0;
                        dis_dat_o <= w_is_match ? w_best_dis : 7'd0;
                        r_pp      <= r_pp + w_adv;
                        r_hist    <= (w_hist_sum > 8'(WINDOW_SIZE)) ?
                                     7'(WINDOW_SIZE) : w_hist_sum[6:0];
                    end
                    r_avail <= w_avail_next;
                    if (r_state == S_RUN) begin
                        if (w_accept && lst_i) begin
                            r_state <= S_FLUSH;
                        end else begin
                            rdy_o <= (w_avail_next < 7'(NICE_MATCH));
                        end
                    end else if (w_emit && (w_adv == r_avail)) begin
                        // This token consumes the rest of the lookahead.
                        lst_o   <= 1'b1;
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    done_o  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lz77_greedy.sv
// -----------------------------------------------------------------------------
// tb_lz77_greedy
// Scoreboard bench for lz77_greedy. Each stream is tokenized by a plain
// reference model of the greedy LZ77 rule, and its tokens are queued. A
// separate monitor pops and compares whenever val_o is high. The monitor also
// checks per-cycle zeroing and the done_o timing.
// -----------------------------------------------------------------------------
module tb_lz77_greedy;

    localparam int W = 32;
    localparam int N = 32;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start_i = 1'b0;
    logic       val_i = 1'b0;
    logic [7:0] dat_i = 8'd0;
    logic       lst_i = 1'b0;
    logic       rdy_o, val_o, flg_lit_o, lst_o, done_o;
    logic [7:0] lit_dat_o;
    logic [6:0] len_dat_o, dis_dat_o;

    typedef struct packed {
        logic       lit;
        logic [7:0] ld;
        logic [6:0] len;
        logic [6:0] dis;
        logic       lst;
    } tok_t;

    tok_t       exp_q[$];
    logic [7:0] stim[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_tok_cyc = 0;
    bit         mon_en = 1'b0;
    bit         prev_lst = 1'b0;
    tok_t       mon_got, mon_exp;

    lz77_greedy #(.WINDOW_SIZE(W), .NICE_MATCH(N)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start_i   (start_i),
        .val_i     (val_i),
        .dat_i     (dat_i),
        .lst_i     (lst_i),
        .rdy_o     (rdy_o),
        .val_o     (val_o),
        .flg_lit_o (flg_lit_o),
        .lit_dat_o (lit_dat_o),
        .len_dat_o (len_dat_o),
        .dis_dat_o (dis_dat_o),
        .lst_o     (lst_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string msg);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s", msg);
        end
    endtask

    // Greedy LZ77 reference: try every distance, extend while bytes agree,
    // cap at N and at the end of the stream, and keep the first longest.
    function automatic void model();
        int   n, p, best, bd, l;
        tok_t t;
        n = stim.size();
        p = 0;
        while (p < n) begin
            best = 0;
            bd   = 0;
            for (int d = 1; d <= W && d <= p; d++) begin
                l = 0;
                while (l < N && p + l < n && stim[p + l] == stim[p + l - d]) l++;
                if (l > best) begin
                    best = l;
                    bd   = d;
                end
            end
            t = '0;
            if (best >= 3) begin
                t.len = 7'(best);
                t.dis = 7'(bd);
                p += best;
            end else begin
                t.lit = 1'b1;
                t.ld  = stim[p];
                p++;
            end
            t.lst = (p == n);
            exp_q.push_back(t);
        end
    endfunction

    task automatic set_str(input string s);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    task automatic set_fill(input int n, input logic [7:0] b);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(b);
    endtask

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (val_o) begin
                    mon_got = {flg_lit_o, lit_dat_o, len_dat_o, dis_dat_o, lst_o};
                    $display("token lit=%0b byte=%02h len=%0d dis=%0d lst=%0b",
                             flg_lit_o, lit_dat_o, len_dat_o, dis_dat_o, lst_o);
                    if (exp_q.size() == 0) begin
                        chk(1'b0, $sformatf("token_extra got=%h required=none", mon_got));
                    end else begin
                        mon_exp = exp_q.pop_front();
                        chk(mon_got == mon_exp,
                            $sformatf("token got=%h required=%h", mon_got, mon_exp));
                    end
                    if (lst_o) last_tok_cyc = cyc;
                end else begin
                    chk({flg_lit_o, lit_dat_o, len_dat_o, dis_dat_o, lst_o} == 24'd0,
                        $sformatf("idle_zero got=%h required=0",
                                  {flg_lit_o, lit_dat_o, len_dat_o, dis_dat_o, lst_o}));
                end
                if (done_o || prev_lst)
                    chk(done_o == prev_lst,
                        $sformatf("done_timing got=%0b required=%0b", done_o, prev_lst));
                prev_lst = val_o && lst_o;
            end
        end
    end

    // Pulse start_i, then check the three quiet cycles and the first ready.
    task automatic do_start();
        start_i = 1'b1;
        @(posedge clk); @(negedge clk);
        start_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) begin
                chk(!rdy_o && !val_o,
                    $sformatf("hold_c%0d got rdy=%0b val=%0b required rdy=0 val=0", k, rdy_o, val_o));
                @(posedge clk); @(negedge clk);
            end else begin
                chk(rdy_o && !val_o,
                    $sformatf("run_c4 got rdy=%0b val=%0b required rdy=1 val=0", rdy_o, val_o));
            end
        end
    endtask

    task automatic run(input int start_at, input int abort_at, input int pre_idle, input bit gaps);
        int i, guard, acc_cyc, lat;
        bit acc, aborted;
        repeat (pre_idle) begin @(posedge clk); @(negedge clk); end
        model();
        do_start();
        i = 0; guard = 0; acc_cyc = 0; aborted = 1'b0;
        while (i < stim.size()) begin
            if (i == abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (guard > 3000) begin
                chk(1'b0, $sformatf("send_timeout got=%0d bytes required=%0d", i, stim.size()));
                break;
            end
            val_i   = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            dat_i   = stim[i];
            lst_i   = (i == stim.size() - 1);
            start_i = (i == start_at);
            acc     = val_i && rdy_o;
            if (acc && lst_i) acc_cyc = cyc + 1;
            @(posedge clk); @(negedge clk);
            if (acc) i++;
            guard++;
        end
        val_i = 1'b0; lst_i = 1'b0; start_i = 1'b0;
        if (aborted) begin
            rstn = 1'b0;
            @(posedge clk); @(negedge clk);
            rstn = 1'b1;
            exp_q.delete();
            chk({rdy_o, val_o, flg_lit_o, lit_dat_o, len_dat_o, dis_dat_o, lst_o, done_o} == 27'd0,
                $sformatf("reset_mid got=%h required=0",
                          {rdy_o, val_o, flg_lit_o, lit_dat_o, len_dat_o, dis_dat_o, lst_o, done_o}));
            repeat (60) begin
                @(posedge clk); @(negedge clk);
                chk(!rdy_o && !val_o && !done_o,
                    $sformatf("after_abort got rdy=%0b val=%0b done=%0b required 0 0 0", rdy_o, val_o, done_o));
            end
            return;
        end
        guard = 0;
        while (!done_o && guard < N + 200) begin
            @(posedge clk); @(negedge clk);
            guard++;
        end
        chk(done_o == 1'b1, $sformatf("done_wait got=%0b required=1", done_o));
        chk(exp_q.size() == 0, $sformatf("tokens_left got=%0d required=0", exp_q.size()));
        lat = last_tok_cyc - acc_cyc;
        chk(lat >= 1 && lat <= N + 4, $sformatf("latency got=%0d required=1..%0d", lat, N + 4));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({rdy_o, val_o, flg_lit_o, lit_dat_o, len_dat_o, dis_dat_o, lst_o, done_o} == 27'd0,
            $sformatf("reset got=%h required=0",
                      {rdy_o, val_o, flg_lit_o, lit_dat_o, len_dat_o, dis_dat_o, lst_o, done_o}));
        rstn   = 1'b1;
        mon_en = 1'b1;

        set_str("abc");          run(-1, -1, 2, 1'b1);
        set_fill(10, 8'h41);     run(-1, -1, 3, 1'b1);
        set_str("abcXabcYabc");  run(-1, -1, 1, 1'b1);
        set_fill(70, 8'h00);     run(-1, -1, 2, 1'b1);
        set_str("aaaa");         run(-1, -1, 2, 1'b0);
        set_str("aaaa");         run(1, -1, 0, 1'b0);
        set_fill(70, 8'h00);     run(-1, 40, 2, 1'b1);
        set_str("abc");          run(-1, -1, 2, 1'b1);
        set_str("Z");            run(-1, -1, 0, 1'b1);

        for (int s = 0; s < 14; s++) begin
            int n;
            n = $urandom_range(1, 90);
            stim.delete();
            for (int i = 0; i < n; i++) begin
                if (s % 3 == 2) stim.push_back(8'($urandom_range(0, 255)));
                else            stim.push_back(8'h61 + 8'($urandom_range(0, 2)));
            end
            run(-1, -1, $urandom_range(0, 3), 1'b1);
        end

        repeat (3) begin @(posedge clk); @(negedge clk); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
